jtag_reg_master: RTL

Debug-side initiator for the register file's JTAG port. Accepts register read/write commands from the JTAG debug transport over a valid/ready handshake, halts the core, performs the access on the register file's jtagw_*/jtagr_data port, and returns data and status over a response handshake. Sits between the debug transport module and the register file, in the core clock domain.

---
 rtl/jtag_reg_master_pkg.sv | 30 +++
 rtl/jtag_reg_master_if.sv | 24 ++
 rtl/jtag_timeout_cnt.sv | 29 ++
 rtl/jtag_reg_master.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/jtag_reg_master_pkg.sv
// Shared encodings for the JTAG register master: command opcodes, response error
// codes, FSM states and the register-file constants used by the access path.
package jtag_reg_master_pkg;

  typedef enum logic [1:0] {
    JtagOpRsvd   = 2'b00,
    JtagOpRead   = 2'b01,
    JtagOpWrite  = 2'b10,
    JtagOpResume = 2'b11
  } jtag_op_e;

  typedef enum logic [1:0] {
    ErrOk            = 2'b00,
    ErrIllegalOp     = 2'b01,
    ErrHaltTimeout   = 2'b10,
    ErrWrSlotTimeout = 2'b11
  } jtag_err_e;

  typedef enum logic [1:0] {
    StIdle,
    StHalt,
    StAccess,
    StResp
  } jtag_state_e;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg     = 5'd0;
  localparam logic        WriteEnable = 1'b1;

endpackage

// File: rtl/jtag_reg_master_if.sv
// Command/response handshake between the debug transport and the JTAG register master.
// master: transport side (issues commands, consumes responses).
// slave:  register master side.
interface jtag_reg_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_timeout_cnt.sv
// 8-bit clear/increment counter with an expiry flag raised on the increment that
// reaches HALT_TIMEOUT (legal range 1..255).
module jtag_timeout_cnt #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt_q;

  // Combinational so the FSM leaves on the same edge that the count hits the limit.
  assign expired = inc && (({1'b0, cnt_q} + 9'd1) == 9'(HALT_TIMEOUT));

  // Wait-cycle counter; clear has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_reg_master.sv
// JTAG register master: accepts read/write/resume commands from the debug transport,
// halts the core, accesses the register file through its JTAG port and returns a
// response. Optional build macro JTAG_AUTO_RESUME_EN releases halt_req after every
// completed read/write response; without it halt_req is held until a resume op.
module jtag_reg_master
  import jtag_reg_master_pkg::*;
#(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  jtag_reg_master_if.slave         bus,
  output logic                     halt_req,
  input  logic                     halted,
  input  logic                     exw_enable,
  output logic                     jtagw_enable,
  output logic [4:0]               jtagw_addr,
  output logic [31:0]              jtagw_data,
  input  logic [31:0]              jtagr_data
);

  jtag_state_e state_q;
  jtag_op_e    op_q;
  jtag_err_e   rsp_err_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        halt_req_q;
  logic        wr_slot_q;
  logic [4:0]  jtagw_addr_q;
  logic [31:0] jtagw_data_q;

  logic cnt_inc;
  logic cnt_clr;
  logic cnt_expired;

  // Count only cycles spent waiting: HALT without ack, or a write blocked by EX writeback.
  always_comb begin
    cnt_inc = 1'b0;
    unique case (state_q)
      StHalt:   cnt_inc = !halted;
      StAccess: cnt_inc = (op_q == JtagOpWrite) && exw_enable;
      default:  cnt_inc = 1'b0;
    endcase
  end

  assign cnt_clr = !cnt_inc || cnt_expired;

  jtag_timeout_cnt #(
    .HALT_TIMEOUT(HALT_TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .expired (cnt_expired)
  );

  // Command FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      op_q         <= JtagOpRsvd;
      rsp_err_q    <= ErrOk;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= ZeroWord;
      halt_req_q   <= 1'b0;
      wr_slot_q    <= 1'b0;
      jtagw_addr_q <= ZeroReg;
      jtagw_data_q <= ZeroWord;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_ready_q && bus.req_valid) begin
            req_ready_q <= 1'b0;
            op_q        <= jtag_op_e'(bus.req_op);
            unique case (jtag_op_e'(bus.req_op))
              JtagOpRead, JtagOpWrite: begin
                jtagw_addr_q <= bus.req_addr;
                jtagw_data_q <= bus.req_data;
                halt_req_q   <= 1'b1;
                state_q      <= StHalt;
              end
              JtagOpResume: begin
                halt_req_q  <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= ZeroWord;
                rsp_err_q   <= ErrOk;
                state_q     <= StResp;
              end
              default: begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= ZeroWord;
                rsp_err_q   <= ErrIllegalOp;
                state_q     <= StResp;
              end
            endcase
          end else begin
            // Also covers the first cycle out of reset, when ready is still low.
            req_ready_q <= 1'b1;
          end
        end
        StHalt: begin
          if (halted) begin
            wr_slot_q <= (op_q == JtagOpWrite) ? WriteEnable : 1'b0;
            state_q   <= StAccess;
          end else if (cnt_expired) begin
            halt_req_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ZeroWord;
            rsp_err_q   <= ErrHaltTimeout;
            state_q     <= StResp;
          end
        end
        StAccess: begin
          if (op_q == JtagOpRead) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= jtagr_data;
            rsp_err_q   <= ErrOk;
            state_q     <= StResp;
          end else if (!exw_enable) begin
            wr_slot_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ZeroWord;
            rsp_err_q   <= ErrOk;
            state_q     <= StResp;
          end else if (cnt_expired) begin
            wr_slot_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ZeroWord;
            rsp_err_q   <= ErrWrSlotTimeout;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
`ifdef JTAG_AUTO_RESUME_EN
            if (op_q == JtagOpRead || op_q == JtagOpWrite) begin
              halt_req_q <= 1'b0;
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign halt_req      = halt_req_q;
  assign jtagw_addr    = jtagw_addr_q;
  assign jtagw_data    = jtagw_data_q;
  // The write slot is only usable in cycles the EX stage is not writing back; the regfile
  // arbitrates in the same cycle, so the strobe must follow exw_enable without a stage.
  assign jtagw_enable  = wr_slot_q && !exw_enable;

endmodule
